ping_pong_sequencer: RTL and testbench

Controller that configures and paces the parameterized ping-pong counter. It accepts a {max, min, bounce limit} configuration over a valid/ready handshake and rejects invalid ranges. It resets the counter to the new min and generates the counter's `enable` at a divided rate, plus single-cycle `flip` strobes. It also counts turnarounds and stops the counter after a programmed number of bounces. It sits between the board input logic (debounced, one-pulsed buttons and switches) and the counter instance.

---
 rtl/ping_pong_pkg.sv | 15 +
 rtl/ping_pong_tick_gen.sv | 29 ++
 rtl/ping_pong_sequencer.sv | 154 +++++++++++++++
 tb/tb_ping_pong_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// Shared widths and FSM state encodings for the ping-pong sequencer.
package ping_pong_pkg;

  localparam int unsigned WIDTH_DEF  = 4;
  localparam int unsigned BWIDTH_DEF = 4;
  localparam int unsigned STATE_W    = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ping_pong_tick_gen.sv
// Divides RUN time into windows of TICK_DIV cycles and flags the last cycle of each.
module ping_pong_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/ping_pong_sequencer.sv
// Configures, paces and bounce-limits a ping-pong counter from board-level requests.
module ping_pong_sequencer
  import ping_pong_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned BWIDTH   = BWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [WIDTH-1:0]   i_cfg_max,
  input  logic [WIDTH-1:0]   i_cfg_min,
  input  logic [BWIDTH-1:0]  i_cfg_bounces,
  output logic               o_cfg_err,
  input  logic               i_run_req,
  input  logic               i_stop_req,
  input  logic               i_flip_req,
  input  logic               i_cnt_direction,
  output logic               o_cnt_rst_n,
  output logic               o_cnt_enable,
  output logic               o_cnt_flip,
  output logic [WIDTH-1:0]   o_cnt_max,
  output logic [WIDTH-1:0]   o_cnt_min,
  output logic [STATE_W-1:0] o_state,
  output logic               o_done
);

  state_t            r_state, w_nxt_state;
  logic              r_load, w_nxt_load;
  logic              r_configured, w_nxt_configured;
  logic [WIDTH-1:0]  r_cnt_max, w_nxt_cnt_max;
  logic [WIDTH-1:0]  r_cnt_min, w_nxt_cnt_min;
  logic [BWIDTH-1:0] r_limit, w_nxt_limit;
  logic [BWIDTH-1:0] r_bounce, w_nxt_bounce, w_bounce_inc;
  logic              r_flip_pend, w_nxt_flip_pend;
  logic              r_cfg_err, w_nxt_cfg_err;
  logic              r_cfg_ready, r_done, r_cnt_rst_n;
  logic              r_dir_q, r_flip_q;
  logic              w_tick, w_tick_clr, w_cnt_flip;
  logic              w_cfg_fire, w_cfg_ok, w_run_ok, w_turn, w_limit_hit;

  ping_pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tick_clr),
    .i_en   (r_state == ST_RUN),
    .o_tick (w_tick)
  );

  assign w_cnt_flip   = r_flip_pend && w_tick;
  assign w_cfg_fire   = i_cfg_valid && r_cfg_ready;
  assign w_cfg_ok     = i_cfg_max > i_cfg_min;
  assign w_run_ok     = i_run_req && !i_stop_req;
  // A direction change caused by our own flip is not a bounce.
  assign w_turn       = (r_state == ST_RUN) && (i_cnt_direction != r_dir_q) && !r_flip_q;
  assign w_bounce_inc = (r_bounce == '1) ? r_bounce : r_bounce + BWIDTH'(1);
  assign w_limit_hit  = w_turn && (r_limit != '0) && (w_bounce_inc == r_limit);
  assign w_tick_clr   = (w_nxt_state == ST_RUN) && (r_state != ST_RUN);

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_load       = 1'b0;
    w_nxt_configured = r_configured;
    w_nxt_cnt_max    = r_cnt_max;
    w_nxt_cnt_min    = r_cnt_min;
    w_nxt_limit      = r_limit;
    w_nxt_bounce     = r_bounce;
    w_nxt_flip_pend  = r_flip_pend;
    w_nxt_cfg_err    = 1'b0;

    if (w_turn) w_nxt_bounce = w_bounce_inc;

    if (w_cnt_flip) begin
      w_nxt_flip_pend = 1'b0;
    end else if (i_flip_req && (r_state == ST_RUN || r_state == ST_PAUSE)) begin
      w_nxt_flip_pend = 1'b1;
    end
    if (i_stop_req) w_nxt_flip_pend = 1'b0;

    // An accepted configuration overrides any request in the same cycle.
    if (w_cfg_fire && w_cfg_ok) begin
      w_nxt_cnt_max    = i_cfg_max;
      w_nxt_cnt_min    = i_cfg_min;
      w_nxt_limit      = i_cfg_bounces;
      w_nxt_bounce     = '0;
      w_nxt_configured = 1'b1;
      w_nxt_load       = 1'b1;
      w_nxt_state      = ST_IDLE;
    end else begin
      w_nxt_cfg_err = w_cfg_fire;
      case (r_state)
        ST_IDLE:  if (w_run_ok && r_configured) w_nxt_state = ST_RUN;
        ST_RUN: begin
          if (w_limit_hit)     w_nxt_state = ST_DONE;
          else if (i_stop_req) w_nxt_state = ST_PAUSE;
        end
        ST_PAUSE: if (w_run_ok) w_nxt_state = ST_RUN;
        ST_DONE: begin
          if (w_run_ok) begin
            w_nxt_state  = ST_RUN;
            w_nxt_bounce = '0;
          end
        end
        default:  w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_dir_q <= i_cnt_direction;
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_load       <= 1'b0;
      r_configured <= 1'b0;
      r_cnt_max    <= '1;
      r_cnt_min    <= '0;
      r_limit      <= '0;
      r_bounce     <= '0;
      r_flip_pend  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_done       <= 1'b0;
      r_cnt_rst_n  <= 1'b0;
      r_flip_q     <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_load       <= w_nxt_load;
      r_configured <= w_nxt_configured;
      r_cnt_max    <= w_nxt_cnt_max;
      r_cnt_min    <= w_nxt_cnt_min;
      r_limit      <= w_nxt_limit;
      r_bounce     <= w_nxt_bounce;
      r_flip_pend  <= w_nxt_flip_pend;
      r_cfg_err    <= w_nxt_cfg_err;
      r_cfg_ready  <= !w_nxt_load && (w_nxt_state != ST_RUN);
      r_done       <= (w_nxt_state == ST_DONE);
      r_cnt_rst_n  <= !w_nxt_load;
      r_flip_q     <= w_cnt_flip;
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_cfg_err    = r_cfg_err;
  assign o_cnt_rst_n  = r_cnt_rst_n;
  assign o_cnt_enable = w_tick;
  assign o_cnt_flip   = w_cnt_flip;
  assign o_cnt_max    = r_cnt_max;
  assign o_cnt_min    = r_cnt_min;
  assign o_state      = r_state;
  assign o_done       = r_done;

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Bench for ping_pong_sequencer: vector table, directed counter-driven sequences, random vs. model.
module tb_ping_pong_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned BW = 4;
  localparam int MAXV = (1 << W) - 1;
  localparam int BMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic i_cfg_valid, i_run_req, i_stop_req, i_flip_req, i_cnt_direction;
  logic [W-1:0] i_cfg_max, i_cfg_min;
  logic [BW-1:0] i_cfg_bounces;
  logic o_cfg_ready, o_cfg_err, o_cnt_rst_n, o_cnt_enable, o_cnt_flip, o_done;
  logic [W-1:0] o_cnt_max, o_cnt_min;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  ping_pong_sequencer #(.TICK_DIV(TD), .WIDTH(W), .BWIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_max(i_cfg_max), .i_cfg_min(i_cfg_min), .i_cfg_bounces(i_cfg_bounces),
    .o_cfg_err(o_cfg_err),
    .i_run_req(i_run_req), .i_stop_req(i_stop_req), .i_flip_req(i_flip_req),
    .i_cnt_direction(i_cnt_direction),
    .o_cnt_rst_n(o_cnt_rst_n), .o_cnt_enable(o_cnt_enable), .o_cnt_flip(o_cnt_flip),
    .o_cnt_max(o_cnt_max), .o_cnt_min(o_cnt_min),
    .o_state(o_state), .o_done(o_done)
  );

  int n_chk = 0;
  int n_err = 0;

  // Sampled outputs of the current cycle
  logic [31:0] s_st, s_rdy, s_err, s_crst, s_en, s_fl, s_done, s_max, s_min;

  // Behavioural ping-pong counter that drives the direction input
  bit use_cm = 0;
  int cm_val = 0;
  bit cm_up = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (use_cm) begin
      if (s_crst !== 32'd1) begin
        cm_val = int'(s_min);
        cm_up  = 1'b1;
      end else if (s_en === 32'd1) begin
        if (s_fl === 32'd1) cm_up = !cm_up;
        else if (cm_up) begin
          if (cm_val >= int'(s_max)) begin cm_up = 1'b0; cm_val--; end
          else cm_val++;
        end else begin
          if (cm_val <= int'(s_min)) begin cm_up = 1'b1; cm_val++; end
          else cm_val--;
        end
      end
      i_cnt_direction = cm_up;
    end
    @(negedge clk);
    s_st = 32'(o_state);       s_rdy = 32'(o_cfg_ready); s_err = 32'(o_cfg_err);
    s_crst = 32'(o_cnt_rst_n); s_en = 32'(o_cnt_enable); s_fl = 32'(o_cnt_flip);
    s_done = 32'(o_done);      s_max = 32'(o_cnt_max);   s_min = 32'(o_cnt_min);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
  endtask

  task automatic load_cfg(input int mx, input int mn, input int b);
    i_cfg_valid = 1'b1; i_cfg_max = W'(mx); i_cfg_min = W'(mn); i_cfg_bounces = BW'(b);
    step();
    i_cfg_valid = 1'b0;
    step();
  endtask

  task automatic start_run();
    i_run_req = 1'b1; step(); i_run_req = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit cv; int cmx; int cmn; bit run; bit stop; bit flip;
    int st; bit rdy; bit err; bit crst; bit en; bit fl; int emx; int emn;
  } vec_t;

  function automatic vec_t mk(bit rst, bit cv, int cmx, int cmn, bit run, bit stop, bit flip,
                              int st, bit rdy, bit err, bit crst, bit en, bit fl, int emx, int emn);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cmx = cmx; v.cmn = cmn; v.run = run; v.stop = stop; v.flip = flip;
    v.st = st; v.rdy = rdy; v.err = err; v.crst = crst; v.en = en; v.fl = fl; v.emx = emx; v.emn = emn;
    return v;
  endfunction

  vec_t tv[21];

  // ---------------- reference model ----------------
  int m_st, m_max, m_min, m_lim, m_cnt, m_phase;
  bit m_cfgd, m_load, m_inrst, m_err, m_pend, m_dirp, m_flipp;

  function automatic bit e_en();
    return (m_st == 1) && ((m_phase % int'(TD)) == int'(TD) - 1);
  endfunction

  function automatic bit e_rdy();
    return !m_load && (m_st != 1);
  endfunction

  task automatic model_step();
    bit en, fl, turn, hit, run_ok, accept;
    int nst;
    if (!rst_n) begin
      m_st = 0; m_cfgd = 0; m_load = 0; m_inrst = 1; m_err = 0; m_pend = 0;
      m_max = MAXV; m_min = 0; m_lim = 0; m_cnt = 0; m_phase = 0; m_flipp = 0;
      m_dirp = i_cnt_direction;
      return;
    end
    en = e_en(); fl = m_pend && en;
    turn = (m_st == 1) && (i_cnt_direction != m_dirp) && !m_flipp;
    if (turn) m_cnt = (m_cnt + 1 > BMAX) ? BMAX : m_cnt + 1;
    hit = turn && (m_lim != 0) && (m_cnt == m_lim);
    run_ok = i_run_req && !i_stop_req;
    if (fl) m_pend = 0;
    else if (i_flip_req && (m_st == 1 || m_st == 2)) m_pend = 1;
    if (i_stop_req) m_pend = 0;
    accept = i_cfg_valid && e_rdy() && (int'(i_cfg_max) > int'(i_cfg_min));
    m_err = i_cfg_valid && e_rdy() && !accept;
    nst = m_st;
    if (accept) begin
      m_max = int'(i_cfg_max); m_min = int'(i_cfg_min); m_lim = int'(i_cfg_bounces);
      m_cnt = 0; m_cfgd = 1; nst = 0;
    end else begin
      if (m_st == 0 && run_ok && m_cfgd) nst = 1;
      else if (m_st == 1 && hit) nst = 3;
      else if (m_st == 1 && i_stop_req) nst = 2;
      else if (m_st == 2 && run_ok) nst = 1;
      else if (m_st == 3 && run_ok) begin nst = 1; m_cnt = 0; end
    end
    if (nst == 1 && m_st != 1) m_phase = 0;
    else if (m_st == 1) m_phase++;
    m_st = nst; m_load = accept; m_inrst = 0;
    m_dirp = i_cnt_direction; m_flipp = fl;
  endtask

  int n_en, n_fl, n_bad;

  initial begin
    rst_n = 1'b0; i_cfg_valid = 0; i_run_req = 0; i_stop_req = 0; i_flip_req = 0;
    i_cnt_direction = 0; i_cfg_max = '0; i_cfg_min = '0; i_cfg_bounces = '0;

    //            rst cv mx mn run stp flp | st rdy err crst en fl emx emn
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 15, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 15, 0);
    tv[2]  = mk(1, 1, 3, 3, 0, 0, 0,   0, 1, 1, 1, 0, 0, 15, 0);
    tv[3]  = mk(1, 1, 2, 5, 0, 0, 0,   0, 1, 1, 1, 0, 0, 15, 0);
    tv[4]  = mk(1, 0, 0, 0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 15, 0);
    tv[5]  = mk(1, 1, 5, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5, 2);
    tv[6]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 5, 2);
    tv[7]  = mk(1, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[8]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[9]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[10] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 5, 2);
    tv[11] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[12] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[13] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[14] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 5, 2);
    tv[15] = mk(1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[16] = mk(1, 0, 0, 0, 1, 1, 0,   2, 1, 0, 1, 0, 0, 5, 2);
    tv[17] = mk(1, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[18] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[19] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 5, 2);
    tv[20] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 5, 2);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      rst_n = tv[i].rst; i_cfg_valid = tv[i].cv;
      i_cfg_max = W'(tv[i].cmx); i_cfg_min = W'(tv[i].cmn); i_cfg_bounces = '0;
      i_run_req = tv[i].run; i_stop_req = tv[i].stop; i_flip_req = tv[i].flip;
      step();
      chk($sformatf("tv%0d_state", i), s_st, 32'(tv[i].st));
      chk($sformatf("tv%0d_ready", i), s_rdy, 32'(tv[i].rdy));
      chk($sformatf("tv%0d_err", i), s_err, 32'(tv[i].err));
      chk($sformatf("tv%0d_cnt_rst_n", i), s_crst, 32'(tv[i].crst));
      chk($sformatf("tv%0d_enable", i), s_en, 32'(tv[i].en));
      chk($sformatf("tv%0d_flip", i), s_fl, 32'(tv[i].fl));
      chk($sformatf("tv%0d_done", i), s_done, 32'(tv[i].st == 3));
      chk($sformatf("tv%0d_max", i), s_max, 32'(tv[i].emx));
      chk($sformatf("tv%0d_min", i), s_min, 32'(tv[i].emn));
    end
    i_cfg_valid = 0; i_run_req = 0; i_stop_req = 0; i_flip_req = 0;

    // Flip collapsing: three requests inside one window give one flip, no bounce
    use_cm = 1;
    do_reset(); load_cfg(5, 2, 1); start_run();
    for (int k = 0; k < 20; k++) begin
      if (s_en === 32'd1) break;
      step();
    end
    chk("flip_find_enable", s_en, 32'd1);
    n_fl = 0; n_bad = 0;
    for (int k = 0; k < 8; k++) begin
      i_flip_req = (k < 3);
      step();
      if (s_fl === 32'd1) n_fl++;
      if (s_fl === 32'd1 && s_en !== 32'd1) n_bad++;
    end
    i_flip_req = 0;
    chk("flip_count", 32'(n_fl), 32'd1);
    chk("flip_with_enable", 32'(n_bad), 32'd0);
    chk("flip_no_bounce_state", s_st, 32'd1);

    // Bounce limit of 2 with a live counter, then resume from DONE
    do_reset(); load_cfg(3, 1, 2); start_run();
    n_en = 0;
    for (int k = 0; k < 100; k++) begin
      if (s_done === 32'd1) break;
      step();
      if (s_en === 32'd1) n_en++;
    end
    chk("bounce_done", s_done, 32'd1);
    chk("bounce_enables", 32'(n_en), 32'd5);
    n_en = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_en === 32'd1) n_en++;
    end
    chk("done_no_enable", 32'(n_en), 32'd0);
    chk("done_state", s_st, 32'd3);
    chk("done_max", s_max, 32'd3);
    chk("done_min", s_min, 32'd1);
    start_run();
    chk("resume_state", s_st, 32'd1);
    n_en = 0;
    for (int k = 0; k < 100; k++) begin
      if (s_done === 32'd1) break;
      step();
      if (s_en === 32'd1) n_en++;
    end
    chk("resume_done", s_done, 32'd1);
    chk("resume_enables", 32'(n_en), 32'd4);

    // Reset mid-RUN clears configuration; run is ignored until a new load
    do_reset(); load_cfg(5, 2, 0); start_run(); step(); step();
    rst_n = 1'b0; step();
    chk("rst_state", s_st, 32'd0);
    chk("rst_cnt_rst_n", s_crst, 32'd0);
    chk("rst_max", s_max, 32'(MAXV));
    chk("rst_min", s_min, 32'd0);
    chk("rst_enable", s_en, 32'd0);
    chk("rst_ready", s_rdy, 32'd1);
    rst_n = 1'b1; step();
    start_run(); step();
    chk("rst_run_ignored", s_st, 32'd0);
    load_cfg(6, 1, 0);
    chk("reload_max", s_max, 32'd6);
    start_run();
    chk("reload_run", s_st, 32'd1);

    // Random stimulus against the reference model
    use_cm = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = !(cyc == 0 || $urandom_range(399) == 0);
      i_cfg_valid = ($urandom_range(7) == 0);
      i_cfg_max = W'($urandom); i_cfg_min = W'($urandom);
      i_cfg_bounces = BW'($urandom_range(3));
      i_run_req = ($urandom_range(5) == 0);
      i_stop_req = ($urandom_range(11) == 0);
      i_flip_req = ($urandom_range(4) == 0);
      if ($urandom_range(5) == 0) i_cnt_direction = !i_cnt_direction;
      model_step();
      step();
      chk("rnd_state", s_st, 32'(m_st));
      chk("rnd_ready", s_rdy, 32'(e_rdy()));
      chk("rnd_err", s_err, 32'(m_err));
      chk("rnd_cnt_rst_n", s_crst, 32'(!m_load && !m_inrst));
      chk("rnd_enable", s_en, 32'(e_en()));
      chk("rnd_flip", s_fl, 32'(m_pend && e_en()));
      chk("rnd_done", s_done, 32'(m_st == 3));
      chk("rnd_max", s_max, 32'(m_max));
      chk("rnd_min", s_min, 32'(m_min));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
